// File: rtl/cntr_pkg.sv
// cntr_pkg: FSM state encoding shared by the up/down counter and its next-state decoder.
package cntr_pkg;
   localparam int STATE_W = 3;
   typedef enum logic [STATE_W-1:0] {
      IDLE_STATE = 3'b000,
      LOAD_STATE = 3'b001,
      INC_STATE  = 3'b010,
      INC2_STATE = 3'b011,
      DEC_STATE  = 3'b100,
      DEC2_STATE = 3'b101
   } state_t;
endpackage

// File: rtl/cntr_updown_ns.sv
// cntr_updown_ns: combinational next-state decoder for the two-phase up/down counter FSM.
module cntr_updown_ns
   import cntr_pkg::*;
(
   input  logic               en,
   input  logic               load,
   input  logic               inc,
   input  logic [STATE_W-1:0] state,
   output state_t             next_state
);
   // Codes above DEC2 are illegal and always recover to IDLE.
   always_comb
      next_state = (!en || state > DEC2_STATE) ? IDLE_STATE :
                   load ? LOAD_STATE :
                   inc  ? ((state == INC_STATE) ? INC2_STATE : INC_STATE) :
                          ((state == DEC_STATE) ? DEC2_STATE : DEC_STATE);
endmodule

// File: rtl/cntr_updown_n.sv
// cntr_updown_n: loadable up/down counter with two-phase stepping FSM and terminal-count flags.
// Define CNTR_UPDOWN_SAT_EN to saturate at the range limits instead of wrapping.
module cntr_updown_n
   import cntr_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int STEP  = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic             load,
   input  logic             inc,
   input  logic [WIDTH-1:0] d_in,
   output logic [WIDTH-1:0] d_out,
   output logic [2:0]       o_state,
   output logic             tc_up,
   output logic             tc_dn
);
`ifdef CNTR_UPDOWN_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif
   localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);
   logic [STATE_W-1:0] state;
   state_t             next_state;
   logic [WIDTH:0]     sum, diff;
   logic [WIDTH-1:0]   up_val, dn_val, d_next;
   cntr_updown_ns u_ns (
      .en         (en),
      .load       (load),
      .inc        (inc),
      .state      (state),
      .next_state (next_state)
   );
   // The extra MSB is the carry (up) or borrow (down) of the step.
   assign sum    = {1'b0, d_out} + STEP_X;
   assign diff   = {1'b0, d_out} - STEP_X;
   assign up_val = (SAT_EN && sum[WIDTH])  ? '1 : sum[WIDTH-1:0];
   assign dn_val = (SAT_EN && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
   always_comb
      d_next = (next_state == LOAD_STATE) ? d_in :
               (next_state == INC_STATE || next_state == INC2_STATE) ? up_val :
               (next_state == DEC_STATE || next_state == DEC2_STATE) ? dn_val : d_out;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE_STATE;
         d_out <= '0;
      end else begin
         state <= next_state;
         d_out <= d_next;
      end
   end
   assign o_state = state;
   assign tc_up   = &d_out;
   assign tc_dn   = ~|d_out;
endmodule

// File: tb/tb_cntr_updown_n.sv
// tb_cntr_updown_n: randomized and directed checks of cntr_updown_n (STEP=1 and STEP=3) against an arithmetic model.
module tb_cntr_updown_n;
`ifdef CNTR_UPDOWN_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       en = 1'b0, load = 1'b0, inc = 1'b0;
   logic [7:0] d_in = 8'h00;
   logic [7:0] d1, d3;
   logic [2:0] st1, st3;
   logic       tu1, td1, tu3, td3;
   int         checks = 0, failures = 0;
   int         c1 = 0, s1 = 0, c3 = 0, s3 = 0;

   always #5 clk = ~clk;

   cntr_updown_n #(.WIDTH(8), .STEP(1)) u1 (
      .clk(clk), .reset_n(reset_n), .en(en), .load(load), .inc(inc), .d_in(d_in),
      .d_out(d1), .o_state(st1), .tc_up(tu1), .tc_dn(td1));
   cntr_updown_n #(.WIDTH(8), .STEP(3)) u3 (
      .clk(clk), .reset_n(reset_n), .en(en), .load(load), .inc(inc), .d_in(d_in),
      .d_out(d3), .o_state(st3), .tc_up(tu3), .tc_dn(td3));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // States are numbered by their encodings: 0 idle, 1 load, 2/3 up phases, 4/5 down phases.
   task automatic step_model(input int step, inout int cnt, inout int st);
      int nst;
      if (!en || st > 5) nst = 0;
      else if (load) nst = 1;
      else if (inc) nst = (st == 2) ? 3 : 2;
      else nst = (st == 4) ? 5 : 4;
      if (nst == 1) cnt = int'(d_in);
      else if (nst == 2 || nst == 3) cnt = SAT ? ((cnt + step > 255) ? 255 : cnt + step) : (cnt + step) % 256;
      else if (nst == 4 || nst == 5) cnt = SAT ? ((cnt < step) ? 0 : cnt - step) : (cnt - step + 256) % 256;
      st = nst;
   endtask

   task automatic compare_all();
      check("d_out1", 32'(d1), 32'(c1));
      check("state1", 32'(st1), 32'(s1));
      check("tc_up1", 32'(tu1), 32'(c1 == 255));
      check("tc_dn1", 32'(td1), 32'(c1 == 0));
      check("d_out3", 32'(d3), 32'(c3));
      check("state3", 32'(st3), 32'(s3));
      check("tc_up3", 32'(tu3), 32'(c3 == 255));
      check("tc_dn3", 32'(td3), 32'(c3 == 0));
   endtask

   task automatic cycle();
      @(posedge clk);
      step_model(1, c1, s1);
      step_model(3, c3, s3);
      #1;
      compare_all();
   endtask

   task automatic drive(input logic e, input logic l, input logic i, input logic [7:0] d);
      en = e; load = l; inc = i; d_in = d;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      check("rst_tc_dn", 32'(td1), 32'd1);
      reset_n = 1'b1;
      // Async reset mid-count at 0x5A
      drive(1, 1, 0, 8'h5A);
      cycle();
      drive(1, 0, 1, 8'h00);
      reset_n = 1'b0;
      #2;
      c1 = 0; s1 = 0; c3 = 0; s3 = 0;
      check("async_rst_d", 32'(d1), 32'h0);
      check("async_rst_st", 32'(st1), 32'h0);
      check("async_rst_tc", 32'(td1), 32'h1);
      reset_n = 1'b1;
      // Load wins over inc
      drive(1, 1, 1, 8'hF0);
      cycle();
      check("load_prio_d", 32'(d1), 32'hF0);
      check("load_prio_st", 32'(st1), 32'h1);
      // Up phasing and wrap
      drive(1, 1, 0, 8'hFE);
      cycle();
      drive(1, 0, 1, 8'h00);
      cycle();
      check("up1_d", 32'(d1), 32'hFF);
      check("up1_st", 32'(st1), 32'h2);
      check("up1_tc", 32'(tu1), 32'h1);
      cycle();
      check("up2_d", 32'(d1), SAT ? 32'hFF : 32'h00);
      check("up2_st", 32'(st1), 32'h3);
      cycle();
      check("up3_st", 32'(st1), 32'h2);
      // Down by three from 0x01
      drive(1, 1, 0, 8'h01);
      cycle();
      drive(1, 0, 0, 8'h00);
      cycle();
      check("dn1_d3", 32'(d3), SAT ? 32'h00 : 32'hFE);
      check("dn1_st3", 32'(st3), 32'h4);
      cycle();
      check("dn2_d3", 32'(d3), SAT ? 32'h00 : 32'hFB);
      check("dn2_st3", 32'(st3), 32'h5);
      // en=0 ignores load and holds
      drive(0, 1, 1, 8'h33);
      repeat (3) cycle();
      check("hold_st", 32'(st1), 32'h0);
      // Illegal state recovery
      drive(1, 0, 1, 8'h00);
      force u1.state = 3'b110;
      #1;
      release u1.state;
      s1 = 6;
      #1;
      check("illegal_st", 32'(st1), 32'h6);
      cycle();
      check("recover_st", 32'(st1), 32'h0);
      // Randomized run with boundary-biased load values
      for (int n = 0; n < 400; n++) begin
         logic [7:0] v;
         case ($urandom_range(0, 5))
            0: v = 8'h00;
            1: v = 8'h01;
            2: v = 8'hFE;
            3: v = 8'hFF;
            4: v = 8'h02;
            default: v = 8'($urandom);
         endcase
         drive($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 2, $urandom_range(0, 1) == 1, v);
         if ($urandom_range(0, 99) == 0) begin
            reset_n = 1'b0;
            #1;
            c1 = 0; s1 = 0; c3 = 0; s3 = 0;
            compare_all();
            reset_n = 1'b1;
         end
         cycle();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/cntr_updown_n.md
# cntr_updown_n

Parametrised loadable up/down counter with an embedded 3-bit control FSM. The FSM keeps the two-phase INC/INC2 and DEC/DEC2 stepping scheme of the 8-bit counter. This block adds configurable width, configurable step, a count-enable, and terminal-count flags. It serves as the general counter primitive for the counter and shifter datapaths. All outputs are registered, except the terminal-count flags, which are decoded from the count register.

## Interface
- WIDTH, 8, counter width in bits (≥2)
- STEP, 1, increment/decrement amount (1 ≤ STEP ≤ 2^WIDTH−1)

- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- en  input  1  count enable; 0 forces the FSM to IDLE and holds the count
- load  input  1  load request (highest priority)
- inc  input  1  1 = count up, 0 = count down (used when en=1 and load=0)
- d_in  input  WIDTH  load value
- d_out  output  WIDTH  current count
- o_state  output  3  current FSM state
- tc_up  output  1  d_out == 2^WIDTH−1
- tc_dn  output  1  d_out == 0

## Operation
- States and encoding: IDLE 000, LOAD 001, INC 010, INC2 011, DEC 100, DEC2 101. Codes 110 and 111 are illegal.
- Next-state priority, evaluated from any legal state:
  - en=0 → IDLE
  - else load=1 → LOAD
  - else inc=1 → INC2 if current state is INC, otherwise INC
  - else → DEC2 if current state is DEC, otherwise DEC
- The INC/INC2 and DEC/DEC2 pairs alternate on consecutive same-direction steps. Both members of a pair perform identical arithmetic; the phase is visible only on o_state.
- Count update is selected by next_state and takes effect on the same edge:
  - IDLE: hold
  - LOAD: d_out ← d_in
  - INC/INC2: d_out ← d_out + STEP
  - DEC/DEC2: d_out ← d_out − STEP
- Arithmetic is computed at WIDTH+1 bits; the carry or borrow bit detects overflow.
  - Default: the result wraps modulo 2^WIDTH.
  - Example, WIDTH=8, STEP=3: count 254 + 3 → 1; count 1 − 3 → 254.
- Illegal state (110/111) recovery: next_state is IDLE regardless of inputs and the count holds. Recovery takes one cycle.
- load with en=0 is ignored.

## Timing
- Reset (reset_n=0, asynchronous): o_state=IDLE, d_out=0, therefore tc_dn=1 and tc_up=0.
- Reset asserted mid-count: outputs go to their reset values immediately, without waiting for a clock edge.
- Reset release: the first rising edge with reset_n=1 applies normal transitions.
- Latency: an input sampled at edge N is reflected on d_out and o_state after edge N. There is no additional pipeline stage.
- tc_up and tc_dn are combinational from d_out, so they are valid in the same cycle as d_out.
- Simultaneous load and inc: load wins.
- Holding load=1: the FSM stays in LOAD and reloads d_in every cycle.

## Configuration
- CNTR_UPDOWN_SAT_EN defined: the counter saturates instead of wrapping.
  - Up: if d_out + STEP > 2^WIDTH−1, d_out ← 2^WIDTH−1.
  - Down: if d_out < STEP, d_out ← 0.
  - The FSM still advances INC↔INC2 and DEC↔DEC2 while clamped.
- CNTR_UPDOWN_SAT_EN undefined: modulo wrap as described in Operation.
- Ports and reset values are identical in both builds.

## Structure
- Package cntr_pkg holds:
  - the state typedef (3-bit) with constants IDLE_STATE, LOAD_STATE, INC_STATE, INC2_STATE, DEC_STATE, DEC2_STATE
  - the state width constant
- Sub-module cntr_updown_ns: purely combinational next-state decoder with inputs en, load, inc, state and output next_state.
- The top level contains the state register, count register, arithmetic, saturation logic, and tc decode.

## Test plan
All scenarios use WIDTH=8.

- Reset: reset_n=0 asynchronously mid-count at d_out=0x5A → d_out=0x00, o_state=000, tc_dn=1 before the next edge.
- Load priority: d_in=0xF0, load=1, inc=1, en=1 for 1 cycle → d_out=0xF0, o_state=001.
- Up phasing and wrap (STEP=1): from 0xFE, inc=1 for 3 cycles → d_out 0xFF (INC, tc_up=1), 0x00 (INC2, tc_dn=1), 0x01 (INC).
- Down with step (STEP=3): from 0x01, inc=0 for 2 cycles → 0xFE (DEC), 0xFB (DEC2). With CNTR_UPDOWN_SAT_EN: 0x00, 0x00.
- Enable hold: en=0 with load=1, d_in=0x33 → FSM to IDLE, d_out unchanged for all cycles with en=0.
- Illegal state: force state=110, release → o_state=IDLE after one edge, d_out held.
